dmem_lsu: RTL
=============

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter XLEN, default 64, data width; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 64, byte-address width.
REQ-003 Parameter MAX_WAIT, default 255, maximum cycles to wait for mem_ack before timeout.
REQ-004 clk  input  1  sole clock; every register is updated on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 lsu_valid  input  1  pipeline request; held high until lsu_done.
REQ-007 dm_rd_ctrl  input  3  load type: 0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwu, 7 ld.
REQ-008 dm_wr_ctrl  input  3  store type: 0 none, 1 sb, 2 sh, 3 sw, 4 sd; 5-7 illegal.
REQ-009 dm_addr  input  ADDR_W  byte address.
REQ-010 dm_din  input  XLEN  store data, right-aligned.
REQ-011 lsu_stall  output  1  high while a request is in flight.
REQ-012 lsu_done  output  1  one-cycle completion pulse.
REQ-013 dm_dout  output  XLEN  extended load result; valid while lsu_done is high.
REQ-014 lsu_err  output  2  error code, valid with lsu_done: 0 ok, 1 misaligned, 2 illegal, 3 timeout.
REQ-015 mem_req  output  1  memory request; held high until mem_ack.
REQ-016 mem_we  output  1  write strobe.
REQ-017 mem_addr  output  ADDR_W  word-aligned address (low log2(XLEN/8) bits zero).
REQ-018 mem_wdata  output  XLEN  lane-shifted store data.
REQ-019 mem_be  output  XLEN/8  byte enables.
REQ-020 mem_rdata  input  XLEN  word read data, valid with mem_ack.
REQ-021 mem_ack  input  1  one-cycle acknowledge; any latency of at least 1 cycle after mem_req.

Function
REQ-022 The FSM SHALL have four states: IDLE, CHECK, WAIT, DONE.
REQ-023 IDLE SHALL go to CHECK and latch ctrl, address and data when lsu_valid is high and either ctrl field is nonzero; lsu_valid with both fields zero SHALL be ignored.
REQ-024 CHECK SHALL flag illegal and go to DONE when both ctrl fields are nonzero, when dm_wr_ctrl is 5-7, or when XLEN=32 and the access is ld, lwu or sd.
REQ-025 CHECK SHALL flag misaligned and go to DONE when the address is not a multiple of the access size (2/4/8 bytes); no mem_req is issued for misaligned or illegal requests.
REQ-026 Otherwise CHECK SHALL assert mem_req with registered mem_addr, mem_we, mem_be and mem_wdata, and go to WAIT.
REQ-027 WAIT SHALL hold all mem_* outputs stable until mem_ack; on mem_ack it SHALL drop mem_req and capture mem_rdata on the same edge, then go to DONE.
REQ-028 A wait counter SHALL increment every cycle in WAIT; if it reaches MAX_WAIT without mem_ack, the block SHALL drop mem_req, set err=3 and go to DONE; a mem_ack arriving after the timeout SHALL be ignored.
REQ-029 DONE SHALL pulse lsu_done for one cycle, then return to IDLE.
REQ-030 lsu_stall SHALL equal (state != IDLE && state != DONE) OR (state == IDLE && accepting).
REQ-031 Byte lane = addr[log2(XLEN/8)-1:0]; mem_be SHALL equal the size mask shifted left by the lane; mem_wdata SHALL equal dm_din shifted left by 8*lane.
REQ-032 The load result SHALL be mem_rdata shifted right by 8*lane, then sign-extended (lb/lh/lw) or zero-extended (lbu/lhu/lwu) to XLEN; ld passes through unchanged.
REQ-033 dm_dout SHALL be 0 whenever lsu_err != 0 or the access is a store.
REQ-034 Minimum latency for a legal access SHALL be: accept at edge 0, mem_req high after edge 1, mem_ack at edge k (k >= 2), lsu_done high for one cycle after edge k.

Reset
REQ-035 On rst=1 at a clock edge: state IDLE, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, lsu_done 0, lsu_stall 0, lsu_err 0, dm_dout 0, wait counter 0.
REQ-036 Reset asserted mid-transaction SHALL abort it; no lsu_done is produced, and a subsequent stale mem_ack in IDLE SHALL be ignored.

Structure
REQ-037 The load/store ctrl encodings, the error codes and the state enum SHALL live in shared package rv_mem_pkg.
REQ-038 Lane shifting and load extension SHALL be a combinational sub-module lsu_align; the FSM and counter stay in dmem_lsu.

Verification
REQ-039 XLEN=64: lb at 0x1003, mem_rdata=0x00000000_80000000, ack latency 1 -> dout=0xFFFFFFFF_FFFFFF80, err=0, done 3 cycles after accept.
REQ-040 sh at 0x1006, din=0xABCD -> mem_be=0xC0, mem_wdata=0xABCD0000_00000000, mem_addr=0x1000, mem_we=1.
REQ-041 lw at 0x1002 -> err=1, mem_req never asserted, done 2 cycles after accept.
REQ-042 ld with ack held off and MAX_WAIT=4 -> mem_req drops after 4 WAIT cycles, err=3; a late ack is ignored.
REQ-043 rd_ctrl=1 with wr_ctrl=1 -> err=2; XLEN=32 ld -> err=2.
REQ-044 rst raised during WAIT -> all outputs 0 on the next cycle and no done pulse; a new lwu then completes with dout zero-extended.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the data-memory load/store unit: ctrl codes, error codes, FSM states.
package rv_mem_pkg;

  typedef enum logic [2:0] {
    RD_NONE, RD_LB, RD_LBU, RD_LH, RD_LHU, RD_LW, RD_LWU, RD_LD
  } rd_ctrl_e;

  typedef enum logic [2:0] {
    WR_NONE, WR_SB, WR_SH, WR_SW, WR_SD
  } wr_ctrl_e;

  typedef enum logic [1:0] {
    ERR_OK, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT
  } lsu_err_e;

  typedef enum logic [1:0] {
    S_IDLE, S_CHECK, S_WAIT, S_DONE
  } lsu_state_e;

  // Access size in bytes; a load takes precedence when both fields are set.
  function automatic logic [3:0] access_bytes(input logic [2:0] rd, input logic [2:0] wr);
    logic [3:0] n;
    n = 4'd1;
    if (rd != RD_NONE) begin
      case (rd)
        RD_LH, RD_LHU: n = 4'd2;
        RD_LW, RD_LWU: n = 4'd4;
        RD_LD:         n = 4'd8;
        default:       n = 4'd1;
      endcase
    end else begin
      case (wr)
        WR_SH:   n = 4'd2;
        WR_SW:   n = 4'd4;
        WR_SD:   n = 4'd8;
        default: n = 4'd1;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module lsu_align
  import rv_mem_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int NB = XLEN / 8,
  localparam int LANE_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]        rd_ctrl,
  input  logic [3:0]        size_bytes,
  input  logic [LANE_W-1:0] lane,
  input  logic [XLEN-1:0]   din,
  input  logic [XLEN-1:0]   rdata,
  output logic [NB-1:0]     be,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data
);

  logic [8:0]        mask_full;
  logic [LANE_W+2:0] bit_sh;
  logic [XLEN-1:0]   shifted;

  always_comb begin
    bit_sh    = {lane, 3'b000};
    mask_full = (9'd1 << size_bytes) - 9'd1;
    be        = NB'(mask_full) << lane;
    wdata     = din << bit_sh;
    shifted   = rdata >> bit_sh;
    case (rd_ctrl)
      RD_LB:   load_data = XLEN'($signed(shifted[7:0]));
      RD_LBU:  load_data = XLEN'(shifted[7:0]);
      RD_LH:   load_data = XLEN'($signed(shifted[15:0]));
      RD_LHU:  load_data = XLEN'(shifted[15:0]);
      RD_LW:   load_data = XLEN'($signed(shifted[31:0]));
      RD_LWU:  load_data = XLEN'(shifted[31:0]);
      RD_LD:   load_data = shifted;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: validates a pipeline request, runs one memory handshake with timeout,
// and returns an aligned, extended load result with an error code.
module dmem_lsu
  import rv_mem_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int ADDR_W   = 64,
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lsu_valid,
  input  logic [2:0]          dm_rd_ctrl,
  input  logic [2:0]          dm_wr_ctrl,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [XLEN-1:0]     dm_din,
  output logic                lsu_stall,
  output logic                lsu_done,
  output logic [XLEN-1:0]     dm_dout,
  output logic [1:0]          lsu_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ack
);

  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = $clog2(MAX_WAIT + 1);

  lsu_state_e        state;
  logic [2:0]        rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   din_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic              accepting, illegal, misaligned;
  logic [3:0]        size_b;
  logic [NB-1:0]     be_c;
  logic [XLEN-1:0]   wdata_c, load_c;

  assign accepting = (state == S_IDLE) && lsu_valid &&
                     ((dm_rd_ctrl != RD_NONE) || (dm_wr_ctrl != WR_NONE));
  assign lsu_stall = (state == S_CHECK) || (state == S_WAIT) || accepting;

  assign size_b     = access_bytes(rd_q, wr_q);
  assign misaligned = (addr_q[3:0] & (size_b - 4'd1)) != 4'd0;
  // A 32-bit datapath cannot carry doubleword or zero-extended-word accesses.
  assign illegal    = ((rd_q != RD_NONE) && (wr_q != WR_NONE)) || (wr_q > WR_SD) ||
                      ((XLEN == 32) && ((rd_q == RD_LD) || (rd_q == RD_LWU) || (wr_q == WR_SD)));

  lsu_align #(.XLEN(XLEN)) u_align (
    .rd_ctrl    (rd_q),
    .size_bytes (size_b),
    .lane       (addr_q[LANE_W-1:0]),
    .din        (din_q),
    .rdata      (mem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_data  (load_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_q      <= RD_NONE;
      wr_q      <= WR_NONE;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lsu_done  <= 1'b0;
      lsu_err   <= ERR_OK;
      dm_dout   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accepting) begin
            rd_q   <= dm_rd_ctrl;
            wr_q   <= dm_wr_ctrl;
            addr_q <= dm_addr;
            din_q  <= dm_din;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (illegal) begin
            lsu_err  <= ERR_ILLEGAL;
            lsu_done <= 1'b1;
            state    <= S_DONE;
          end else if (misaligned) begin
            lsu_err  <= ERR_MISALIGN;
            lsu_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= (wr_q != WR_NONE);
            mem_be    <= be_c;
            mem_addr  <= {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            mem_wdata <= wdata_c;
            wait_cnt  <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An acknowledge on the final wait cycle still wins over the timeout.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            dm_dout  <= (wr_q != WR_NONE) ? '0 : load_c;
            lsu_err  <= ERR_OK;
            lsu_done <= 1'b1;
            state    <= S_DONE;
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            mem_req  <= 1'b0;
            dm_dout  <= '0;
            lsu_err  <= ERR_TIMEOUT;
            lsu_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          lsu_done <= 1'b0;
          lsu_err  <= ERR_OK;
          dm_dout  <= '0;
          wait_cnt <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
